// File: rtl/vga_draw_scheduler_pkg.sv
// Shared types and constants for the VGA draw-port scheduler.
package vga_draw_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } draw_state_t;

    localparam int MAP    = 0;
    localparam int PACMAN = 1;
    localparam int GHOST  = 2;

    localparam int COORD_W = 8;
    localparam int COLOR_W = 3;

endpackage

// File: rtl/vga_draw_scheduler_rr_pick.sv
// Round-robin winner select: first requester after last_owner, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [NUM_REQ-1:0] winner
);

    always_comb begin
        int  idx;
        logic found;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_owner) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_draw_scheduler.sv
// Arbitrates the single VGA write port among draw requesters; one owner at a
// time, bursts capped at MAX_BURST plots, with a GAP+IDLE turnaround per grant.
module vga_draw_scheduler
    import vga_draw_scheduler_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int MAX_BURST = 441
) (
    input  logic                         clock_50,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           plot_in,
    input  logic [COORD_W*NUM_REQ-1:0]   x_in,
    input  logic [COORD_W*NUM_REQ-1:0]   y_in,
    input  logic [COLOR_W*NUM_REQ-1:0]   color_in,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         vga_plot,
    output logic [COORD_W-1:0]           vga_x,
    output logic [COORD_W-1:0]           vga_y,
    output logic [COLOR_W-1:0]           vga_color,
    output logic                         busy
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BCNT_W = $clog2(MAX_BURST + 1);
    localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(MAX_BURST);

    draw_state_t         state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    last_owner_q, last_owner_d;
    logic [BCNT_W-1:0]   burst_q, burst_d, burst_inc;
    logic [NUM_REQ-1:0]  grant_d, winner;
    logic                plot_d;
    logic [COORD_W-1:0]  x_d, y_d;
    logic [COLOR_W-1:0]  color_d;
    logic [IDX_W-1:0]    win_idx;
    logic                owner_plot, owner_req;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (req),
        .last_owner (last_owner_q),
        .winner     (winner)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (winner[i]) win_idx = IDX_W'(i);
    end

    assign owner_plot = plot_in[owner_q];
    assign owner_req  = req[owner_q];
    assign burst_inc  = burst_q + 1'b1;
    assign busy       = (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        burst_d      = burst_q;
        grant_d      = grant;
        plot_d       = 1'b0;
        x_d          = vga_x;
        y_d          = vga_y;
        color_d      = vga_color;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (|req) begin
                    state_d      = OWN;
                    grant_d      = winner;
                    owner_d      = win_idx;
                    last_owner_d = win_idx;
                    burst_d      = '0;
                end
            end
            OWN: begin
                if (owner_plot) begin
                    plot_d  = 1'b1;
                    x_d     = x_in[COORD_W*int'(owner_q) +: COORD_W];
                    y_d     = y_in[COORD_W*int'(owner_q) +: COORD_W];
                    color_d = color_in[COLOR_W*int'(owner_q) +: COLOR_W];
                    burst_d = burst_inc;
                end
                // The plot that fills the burst is still forwarded on exit.
                if (!owner_req || (owner_plot && burst_inc == BURST_LAST)) begin
                    state_d = GAP;
                    grant_d = '0;
                end
            end
            GAP: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(NUM_REQ - 1);
            burst_q      <= '0;
            grant        <= '0;
            vga_plot     <= 1'b0;
            vga_x        <= '0;
            vga_y        <= '0;
            vga_color    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_q      <= burst_d;
            grant        <= grant_d;
            vga_plot     <= plot_d;
            vga_x        <= x_d;
            vga_y        <= y_d;
            vga_color    <= color_d;
        end
    end

endmodule

// File: tb/tb_vga_draw_scheduler.sv
// Scoreboard bench: the driver plays every requester and queues the plots the
// owner should see forwarded; a monitor pops and compares on every vga_plot.
module tb_vga_draw_scheduler;

    localparam int NR = 3;
    localparam int MB = 4;

    logic            clock_50;
    logic            reset;
    logic [NR-1:0]   req, plot_in;
    logic [8*NR-1:0] x_in, y_in;
    logic [3*NR-1:0] color_in;
    logic [NR-1:0]   grant;
    logic            vga_plot;
    logic [7:0]      vga_x, vga_y;
    logic [2:0]      vga_color;
    logic            busy;

    vga_draw_scheduler #(.NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .clock_50  (clock_50),
        .reset     (reset),
        .req       (req),
        .plot_in   (plot_in),
        .x_in      (x_in),
        .y_in      (y_in),
        .color_in  (color_in),
        .grant     (grant),
        .vga_plot  (vga_plot),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_color (vga_color),
        .busy      (busy)
    );

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] c;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_cnt = 0;
    int   last_w;
    bit   x99_noise = 0;

    initial begin
        clock_50 = 1'b0;
        forever #10 clock_50 = ~clock_50;
    end

    initial forever begin
        @(posedge clock_50);
        cyc_cnt++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish within 1ms");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc_cnt);
        end
    endtask

    // Round-robin reference: first requester after the previous winner.
    function automatic int rr_model(input logic [NR-1:0] r);
        for (int k = 1; k <= NR; k++)
            if (r[(last_w + k) % NR]) return (last_w + k) % NR;
        return -1;
    endfunction

    // Randomize every requester; optionally override the owner's strobe/data.
    task automatic drive_cycle(input logic [NR-1:0] r, input int o, input bit p,
                               input int fx, input int fy, input int fc);
        for (int i = 0; i < NR; i++) begin
            x_in[8*i +: 8]     = 8'($urandom);
            y_in[8*i +: 8]     = 8'($urandom);
            color_in[3*i +: 3] = 3'($urandom);
            plot_in[i]         = 1'($urandom);
            if (x99_noise) begin
                x_in[8*i +: 8] = 8'd99;
                plot_in[i]     = 1'b1;
            end
        end
        if (o >= 0) begin
            plot_in[o] = p;
            if (x99_noise) x_in[8*o +: 8] = 8'($urandom_range(0, 98));
            if (fx >= 0) x_in[8*o +: 8]     = 8'(fx);
            if (fy >= 0) y_in[8*o +: 8]     = 8'(fy);
            if (fc >= 0) color_in[3*o +: 3] = 3'(fc);
        end
        req = r;
    endtask

    // Play owner o until the grant is expected to drop.
    task automatic own_phase(input int o, input int t, input bit drop_same, input bit dense,
                             input int fx, input int fy, input int fc, input logic [NR-1:0] r);
        int k, cyc;
        bit p, drop, ex;
        logic [NR-1:0] rr;
        exp_t e;
        k = 0; cyc = 0; ex = 0;
        while (!ex && cyc < 50) begin
            p    = (k < t) && (dense || ($urandom % 4 != 0));
            drop = (k >= t);
            if (p) k++;
            if (p && k == t && drop_same) drop = 1;
            rr    = r;
            rr[o] = !drop;
            drive_cycle(rr, o, p, fx, fy, fc);
            if (p) begin
                e.x = x_in[8*o +: 8]; e.y = y_in[8*o +: 8]; e.c = color_in[3*o +: 3];
                e.cyc = cyc_cnt + 1;
                exp_q.push_back(e);
            end
            ex = drop || (p && k == MB);
            @(negedge clock_50);
            cyc++;
            if (ex) begin
                chk("gap_grant", int'(grant), 0);
                chk("gap_busy", int'(busy), 1);
            end else begin
                chk("own_grant", int'(grant), 1 << o);
            end
        end
        if (!ex) begin
            n_cmp++; n_bad++;
            $display("FAIL own_timeout: owner %0d still granted after %0d cycles", o, cyc);
        end
    endtask

    task automatic round(input logic [NR-1:0] r, input bit from_gap, input int t,
                         input bit drop_same, input bit dense,
                         input int fx, input int fy, input int fc);
        int w;
        if (from_gap) begin
            drive_cycle(r, -1, 0, -1, -1, -1);
            @(negedge clock_50);
            chk("idle_grant", int'(grant), 0);
            chk("idle_busy", int'(busy), 0);
        end
        drive_cycle(r, -1, 0, -1, -1, -1);
        w = rr_model(r);
        @(negedge clock_50);
        chk("grant", int'(grant), 1 << w);
        chk("own_busy", int'(busy), 1);
        last_w = w;
        own_phase(w, t, drop_same, dense, fx, fy, fc, r);
    endtask

    // Monitor: every forwarded plot must match the queue head at the right cycle;
    // while vga_plot is low the coordinates must hold.
    initial begin
        exp_t e;
        logic [7:0] lx, ly;
        logic [2:0] lc;
        lx = '0; ly = '0; lc = '0;
        forever begin
            @(negedge clock_50);
            if (!reset) begin
                lx = '0; ly = '0; lc = '0;
            end else if (vga_plot) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d with nothing expected",
                             vga_x, vga_y, vga_color);
                end else begin
                    e = exp_q.pop_front();
                    chk("plot_pix", int'({vga_x, vga_y, vga_color}), int'({e.x, e.y, e.c}));
                    chk("plot_cycle", cyc_cnt, e.cyc);
                end
                lx = vga_x; ly = vga_y; lc = vga_color;
            end else begin
                chk("hold_pix", int'({vga_x, vga_y, vga_color}), int'({lx, ly, lc}));
            end
        end
    end

    initial begin
        int w;
        exp_t e;
        reset = 1'b0;
        req = '0; plot_in = '0; x_in = '0; y_in = '0; color_in = '0;
        repeat (3) @(negedge clock_50);
        chk("rst_grant", int'(grant), 0);
        chk("rst_plot", int'(vga_plot), 0);
        chk("rst_xyc", int'({vga_x, vga_y, vga_color}), 0);
        chk("rst_busy", int'(busy), 0);
        reset  = 1'b1;
        last_w = NR - 1;

        // All three requesting, two plots each: grants rotate 0,1,2,0.
        round(3'b111, 0, 2, 0, 1, -1, -1, -1);
        for (int i = 0; i < 3; i++) round(3'b111, 1, 2, 0, 1, -1, -1, -1);
        // Map alone, one plot of known data.
        round(3'b001, 1, 1, 0, 1, 5, 7, 1);
        // Drop req in the same cycle as the last plot.
        round(3'b001, 1, 1, 1, 1, 20, 20, 3);
        round(3'b110, 1, 1, 0, 1, -1, -1, -1);
        // Burst limit with requester 1 waiting; requester 0 keeps req high.
        round(3'b011, 1, MB + 2, 0, 1, -1, -1, -1);
        // Requester 1 owns while the others strobe x=99.
        x99_noise = 1;
        round(3'b011, 1, 3, 0, 0, -1, -1, -1);
        x99_noise = 0;

        // Reset in the middle of a map burst.
        drive_cycle(3'b001, -1, 0, -1, -1, -1);
        @(negedge clock_50);
        chk("idle_grant", int'(grant), 0);
        drive_cycle(3'b001, -1, 0, -1, -1, -1);
        w = rr_model(3'b001);
        @(negedge clock_50);
        chk("grant", int'(grant), 1 << w);
        last_w = w;
        repeat (2) begin
            drive_cycle(3'b001, 0, 1, -1, -1, -1);
            e.x = x_in[7:0]; e.y = y_in[7:0]; e.c = color_in[2:0]; e.cyc = cyc_cnt + 1;
            exp_q.push_back(e);
            @(negedge clock_50);
            chk("own_grant", int'(grant), 1);
        end
        drive_cycle(3'b101, 0, 1, -1, -1, -1);
        #5 reset = 1'b0;
        #1;
        chk("async_rst_grant", int'(grant), 0);
        chk("async_rst_plot", int'(vga_plot), 0);
        chk("async_rst_xyc", int'({vga_x, vga_y, vga_color}), 0);
        chk("async_rst_busy", int'(busy), 0);
        repeat (2) begin
            @(negedge clock_50);
            chk("in_rst_plot", int'(vga_plot), 0);
        end
        reset  = 1'b1;
        last_w = NR - 1;
        drive_cycle(3'b101, -1, 0, -1, -1, -1);
        @(negedge clock_50);
        chk("post_rst_grant", int'(grant), 3'b001);
        last_w = 0;
        own_phase(0, 2, 0, 0, -1, -1, -1, 3'b101);

        for (int n = 0; n < 40; n++)
            round(3'($urandom_range(1, 7)), 1, $urandom_range(0, MB + 2),
                  1'($urandom), 1'($urandom), -1, -1, -1);

        req = '0; plot_in = '0;
        repeat (3) @(negedge clock_50);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
